// File: rtl/vec_lane_subtractor_pkg.sv
// Shared vALU definitions: SEW codes, slot layout of the guard-slotted difference word, request header types.
// No logic beyond the lane_is_top helper.
package vec_lane_subtractor_pkg;

    localparam int REQ_DATA_WIDTH = 64;
    localparam int SEW_WIDTH      = 2;
    localparam int OPSEL_WIDTH    = 9;
    localparam int TAG_WIDTH      = 4;
    localparam int LANES          = 8;
    localparam int SLOT_W         = 10;
    localparam int GUARD_OFS      = 9;
    localparam int INJ_OFS        = 0;
    localparam int SUB_RESULT_W   = 81;

    typedef enum logic [SEW_WIDTH-1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    typedef struct packed {
        logic [REQ_DATA_WIDTH-1:0] vec0;
        logic [REQ_DATA_WIDTH-1:0] vec1;
        logic [SEW_WIDTH-1:0]      sew;
        logic [OPSEL_WIDTH-1:0]    op_sel;
        logic [TAG_WIDTH-1:0]      tag;
    } hdr_t;

    // A lane is the top byte of its element when its low index bits are all ones for this SEW.
    function automatic logic lane_is_top(input logic [2:0] lane, input logic [SEW_WIDTH-1:0] sew);
        logic [3:0] bpe;
        logic [2:0] msk;
        bpe = 4'd1 << sew;
        msk = bpe[2:0] - 3'd1;
        return (lane & msk) == msk;
    endfunction

endpackage

// File: rtl/vec_lane_subtractor_slot_packer.sv
// Combinational SEW-partitioned subtractor packing each byte lane into a 10-bit guard slot.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// Each element is widened by one bit (sign or zero) so the top bit of the difference is the less-than flag.
module vec_slot_packer
    import vec_lane_subtractor_pkg::*;
(
    input  logic [REQ_DATA_WIDTH-1:0] i_vec0,
    input  logic [REQ_DATA_WIDTH-1:0] i_vec1,
    input  logic [SEW_WIDTH-1:0]      i_sew,
    input  logic                      i_signed,
    output logic [SUB_RESULT_W-1:0]   o_result
);

    logic [63:0] w_diff;
    logic [7:0]  w_esign;
    logic [8:0]  w_d8;
    logic [16:0] w_d16;
    logic [32:0] w_d32;
    logic [64:0] w_d64;
    logic [2:0]  w_elem;

    always_comb begin
        w_diff  = '0;
        w_esign = '0;
        w_d8    = '0;
        w_d16   = '0;
        w_d32   = '0;
        w_d64   = '0;
        case (i_sew)
            SEW_8: begin
                for (int k = 0; k < 8; k++) begin
                    w_d8 = {i_signed & i_vec0[8*k+7], i_vec0[8*k +: 8]}
                         - {i_signed & i_vec1[8*k+7], i_vec1[8*k +: 8]};
                    w_diff[8*k +: 8] = w_d8[7:0];
                    w_esign[k]       = w_d8[8];
                end
            end
            SEW_16: begin
                for (int k = 0; k < 4; k++) begin
                    w_d16 = {i_signed & i_vec0[16*k+15], i_vec0[16*k +: 16]}
                          - {i_signed & i_vec1[16*k+15], i_vec1[16*k +: 16]};
                    w_diff[16*k +: 16] = w_d16[15:0];
                    w_esign[k]         = w_d16[16];
                end
            end
            SEW_32: begin
                for (int k = 0; k < 2; k++) begin
                    w_d32 = {i_signed & i_vec0[32*k+31], i_vec0[32*k +: 32]}
                          - {i_signed & i_vec1[32*k+31], i_vec1[32*k +: 32]};
                    w_diff[32*k +: 32] = w_d32[31:0];
                    w_esign[k]         = w_d32[32];
                end
            end
            default: begin
                w_d64      = {i_signed & i_vec0[63], i_vec0} - {i_signed & i_vec1[63], i_vec1};
                w_diff     = w_d64[63:0];
                w_esign[0] = w_d64[64];
            end
        endcase
    end

    always_comb begin
        o_result = '0;
        w_elem   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_elem = 3'(i) >> i_sew;
            o_result[SLOT_W*i + INJ_OFS]   = 1'b0;
            o_result[SLOT_W*i + 1 +: 8]    = w_diff[8*i +: 8];
            o_result[SLOT_W*i + GUARD_OFS] = lane_is_top(3'(i), i_sew) & w_esign[w_elem];
        end
    end

endmodule

// File: rtl/vec_lane_subtractor.sv
// Two-stage valid/ready vector subtractor feeding the vALU min/max/compare selector with sideband fields aligned.
// Latency: 2 cycles. Backpressure: holds up to two entries, in_ready combinational from out_ready.
// Flush drops both stages on the next edge; a request offered alongside flush is discarded.
module vec_lane_subtractor
    import vec_lane_subtractor_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [REQ_DATA_WIDTH-1:0] vec0,
    input  logic [REQ_DATA_WIDTH-1:0] vec1,
    input  logic [SEW_WIDTH-1:0]      sew,
    input  logic [OPSEL_WIDTH-1:0]    op_sel,
    input  logic [TAG_WIDTH-1:0]      tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SUB_RESULT_W-1:0]   sub_result,
    output logic [REQ_DATA_WIDTH-1:0] out_vec0,
    output logic [REQ_DATA_WIDTH-1:0] out_vec1,
    output logic [SEW_WIDTH-1:0]      out_sew,
    output logic [OPSEL_WIDTH-1:0]    out_op_sel,
    output logic [TAG_WIDTH-1:0]      out_tag
);

    logic                    r_s1_valid;
    logic                    r_s2_valid;
    hdr_t                    r_s1_hdr;
    logic                    r_s1_signed;
    hdr_t                    r_s2_hdr;
    logic [SUB_RESULT_W-1:0] r_s2_res;

    logic                    w_s1_adv;
    logic                    w_s2_adv;
    hdr_t                    w_in_hdr;
    logic [SUB_RESULT_W-1:0] w_slots;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_in_hdr = '{vec0: vec0, vec1: vec1, sew: sew, op_sel: op_sel, tag: tag};

    vec_slot_packer u_packer (
        .i_vec0   (r_s1_hdr.vec0),
        .i_vec1   (r_s1_hdr.vec1),
        .i_sew    (r_s1_hdr.sew),
        .i_signed (r_s1_signed),
        .o_result (w_slots)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_hdr    <= '0;
            r_s1_signed <= 1'b0;
            r_s2_hdr    <= '0;
            r_s2_res    <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s1_adv) r_s1_valid <= in_valid;
                if (w_s2_adv) r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv && in_valid) begin
                r_s1_hdr    <= w_in_hdr;
                r_s1_signed <= in_signed;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_s2_hdr <= r_s1_hdr;
                r_s2_res <= w_slots;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign sub_result = r_s2_res;
    assign out_vec0   = r_s2_hdr.vec0;
    assign out_vec1   = r_s2_hdr.vec1;
    assign out_sew    = r_s2_hdr.sew;
    assign out_op_sel = r_s2_hdr.op_sel;
    assign out_tag    = r_s2_hdr.tag;

endmodule

// File: tb/tb_vec_lane_subtractor.sv
// Bench for vec_lane_subtractor: directed slot checks, backpressure, flush, reset and a randomized stream
// compared against an arithmetic model of the guard-slotted difference word.
module tb_vec_lane_subtractor;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [63:0] vec0, vec1, out_vec0, out_vec1;
    logic [1:0]  sew, out_sew;
    logic [8:0]  op_sel, out_op_sel;
    logic [3:0]  tag, out_tag;
    logic [80:0] sub_result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [80:0] res;
        logic [63:0] v0;
        logic [63:0] v1;
        logic [1:0]  s;
        logic [8:0]  op;
        logic [3:0]  t;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    vec_lane_subtractor dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .vec0(vec0), .vec1(vec1), .sew(sew), .op_sel(op_sel), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .sub_result(sub_result),
        .out_vec0(out_vec0), .out_vec1(out_vec1), .out_sew(out_sew),
        .out_op_sel(out_op_sel), .out_tag(out_tag)
    );

    // Per element: widen to W+1 bits, subtract modulo 2^(W+1), then scatter bytes and the top bit into slots.
    function automatic logic [80:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                          input logic [1:0] s, input logic sg);
        logic [80:0] r;
        logic [64:0] msk, a, b, d, byt;
        int w, bpe, lane;
        r   = '0;
        w   = 8 << s;
        bpe = w / 8;
        msk = (65'd1 << w) - 65'd1;
        for (int k = 0; k < 64 / w; k++) begin
            a = ({1'b0, a_in} >> (w * k)) & msk;
            b = ({1'b0, b_in} >> (w * k)) & msk;
            if (sg && a[w-1]) a = a | ~msk;
            if (sg && b[w-1]) b = b | ~msk;
            d = (a - b) & ((msk << 1) | 65'd1);
            for (int j = 0; j < bpe; j++) begin
                lane = k * bpe + j;
                byt  = (d >> (8 * j)) & 65'hFF;
                r[10*lane+1 +: 8] = byt[7:0];
                if (j == bpe - 1) r[10*lane+9] = d[w];
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                         input logic sg, input logic [8:0] op, input logic [3:0] t);
        in_valid = 1'b1; vec0 = a; vec1 = b; sew = s; in_signed = sg; op_sel = op; tag = t;
    endtask

    // Single request on an idle pipe: checks 2-cycle latency and the full output word.
    task automatic one_req(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                           input logic sg, input logic [3:0] t, output logic [80:0] r);
        logic [80:0] e;
        e = model(a, b, s, sg);
        drive(a, b, s, sg, 9'h1A5, t);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL one_req_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL one_req_early got=%b exp=0", out_valid); end
        step();
        r = sub_result;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL one_req_latency got=%b exp=1", out_valid); end
        total++; if (sub_result !== e) begin bad++; $display("FAIL one_req_result got=%h exp=%h", sub_result, e); end
        total++;
        if (out_tag !== t || out_vec0 !== a || out_vec1 !== b || out_sew !== s || out_op_sel !== 9'h1A5) begin
            bad++; $display("FAIL one_req_fields got tag=%h sew=%h op=%h exp tag=%h sew=%h op=1a5", out_tag, out_sew, out_op_sel, t, s);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0;
        vec0 = '0; vec1 = '0; sew = '0; op_sel = '0; tag = '0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (sub_result !== '0) begin bad++; $display("FAIL reset_sub_result got=%h exp=0", sub_result); end
        total++;
        if (out_tag !== '0 || out_vec0 !== '0 || out_vec1 !== '0 || out_sew !== '0 || out_op_sel !== '0) begin
            bad++; $display("FAIL reset_fields got tag=%h vec0=%h exp 0", out_tag, out_vec0);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [80:0] r, e;
        one_req(64'h01, 64'hFF, 2'd0, 1'b1, 4'h1, r);
        total++; if (r[9:0] !== 10'h004) begin bad++; $display("FAIL signed_byte got=%h exp=004", r[9:0]); end
        total++; if (r[80:10] !== '0) begin bad++; $display("FAIL signed_byte_upper got=%h exp=0", r[80:10]); end
        one_req(64'h01, 64'hFF, 2'd0, 1'b0, 4'h2, r);
        total++; if (r[9:0] !== 10'h204) begin bad++; $display("FAIL unsigned_byte got=%h exp=204", r[9:0]); end
        one_req(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd3, 1'b1, 4'h3, r);
        total++; if (r !== '0) begin bad++; $display("FAIL eq64 got=%h exp=0", r); end
        one_req(64'h0, 64'h1, 2'd3, 1'b1, 4'h4, r);
        e = '0;
        for (int i = 0; i < 8; i++) e[10*i+1 +: 8] = 8'hFF;
        e[79] = 1'b1;
        total++; if (r !== e) begin bad++; $display("FAIL lt64 got=%h exp=%h", r, e); end
        one_req(64'h8000_0000_7FFF_0001, 64'h7FFF_FFFF_8000_0001, 2'd2, 1'b1, 4'h5, r);
        total++; if (r[39] !== 1'b0 || r[79] !== 1'b1) begin bad++; $display("FAIL s32_guards got=%b%b exp=10", r[79], r[39]); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(64'h11, 64'h22, 2'd0, 1'b0, 9'h001, 4'd1);
        #1; total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept1 got=%b exp=1", in_ready); end
        step();
        drive(64'h33, 64'h44, 2'd1, 1'b1, 9'h002, 4'd2);
        #1; total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept2 got=%b exp=1", in_ready); end
        step();
        drive(64'h55, 64'h66, 2'd2, 1'b0, 9'h003, 4'd3);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
            total++; if (out_valid !== 1'b1 || out_tag !== 4'd1) begin bad++; $display("FAIL bp_hold got v=%b tag=%0d exp v=1 tag=1", out_valid, out_tag); end
            step();
        end
        out_ready = 1'b1;
        #1; total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_same_cycle_ready got=%b exp=1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_tag !== 4'(c + 1)) begin
                bad++; $display("FAIL bp_order got v=%b tag=%0d exp v=1 tag=%0d", out_valid, out_tag, c + 1);
            end
            step();
            in_valid = 1'b0;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [80:0] r;
        out_ready = 1'b0;
        drive(64'h5, 64'h1, 2'd0, 1'b0, 9'h005, 4'd5);
        step();
        drive(64'h6, 64'h2, 2'd0, 1'b0, 9'h006, 4'd6);
        step();
        drive(64'h7, 64'h3, 2'd0, 1'b0, 9'h007, 4'd7);
        total++; if (out_valid !== 1'b1 || out_tag !== 4'd5) begin bad++; $display("FAIL flush_pre got v=%b tag=%0d exp v=1 tag=5", out_valid, out_tag); end
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_s2 got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_s1_dropped got=%b exp=0", out_valid); end
        one_req(64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 2'd1, 1'b1, 4'd8, r);
    endtask

    task automatic test_reset_mid();
        logic [80:0] r;
        out_ready = 1'b0;
        drive(64'h09, 64'h03, 2'd0, 1'b0, 9'h009, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        total++; if (sub_result !== '0 || out_tag !== '0) begin bad++; $display("FAIL rstmid_data got res=%h tag=%0d exp 0", sub_result, out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
        one_req(64'h0000_0000_0000_0080, 64'h0000_0000_0000_0001, 2'd0, 1'b1, 4'd10, r);
    endtask

    task automatic test_random(input int n);
        exp_t        e, f;
        int          sent, cycles;
        logic        acc, hold;
        logic [80:0] p_res;
        logic [3:0]  p_tag;
        sent = 0; cycles = 0; hold = 1'b0; p_res = '0; p_tag = '0;
        in_valid = 1'b0;
        while ((sent < n || q.size() > 0) && cycles < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < n && $urandom_range(0, 4) != 0) begin
                e.v0 = {$urandom, $urandom};
                e.v1 = ($urandom_range(0, 3) == 0) ? (e.v0 ^ (64'(1) << $urandom_range(0, 63))) : {$urandom, $urandom};
                if ($urandom_range(0, 5) == 0) e.v1 = e.v0;
                e.s  = 2'($urandom_range(0, 3));
                e.op = 9'($urandom);
                e.t  = 4'(sent);
                in_signed = 1'($urandom);
                e.res = model(e.v0, e.v1, e.s, in_signed);
                drive(e.v0, e.v1, e.s, in_signed, e.op, e.t);
            end
            #1;
            if (hold) begin
                total++;
                if (out_valid !== 1'b1 || sub_result !== p_res || out_tag !== p_tag) begin
                    bad++; $display("FAIL rnd_stable got tag=%0d res=%h exp tag=%0d res=%h", out_tag, sub_result, p_tag, p_res);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious got tag=%0d exp none", out_tag);
                end else begin
                    f = q.pop_front();
                    if (sub_result !== f.res || out_tag !== f.t || out_vec0 !== f.v0 || out_vec1 !== f.v1 ||
                        out_sew !== f.s || out_op_sel !== f.op) begin
                        bad++; $display("FAIL rnd_result got tag=%0d res=%h exp tag=%0d res=%h", out_tag, sub_result, f.t, f.res);
                    end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin q.push_back(e); sent++; end
            hold  = out_valid && !out_ready;
            p_res = sub_result;
            p_tag = out_tag;
            step();
            if (acc) in_valid = 1'b0;
            cycles++;
        end
        in_valid = 1'b0;
        total++;
        if (sent != n || q.size() != 0) begin bad++; $display("FAIL rnd_timeout got sent=%0d left=%0d exp sent=%0d left=0", sent, q.size(), n); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
